multi_squarer: RTL

MULTI_SQUARER -- requirements
Module: multi_squarer

---
 rtl/multi_squarer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/multi_squarer.sv
// Computes c = a^(2^k) in GF(2^M) with polynomial basis, S squarings per clock.
// Each squaring stage is bit interleaving followed by a constant XOR reduction network.
module multi_squarer #(
    parameter int unsigned    M  = 163,
    parameter logic [M-1:0]   F  = M'('hC9),
    parameter int unsigned    S  = 1,
    parameter int unsigned    KW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [M-1:0]  a,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  c
);

    localparam int unsigned NW = KW + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Row j holds x^(M+j) mod f, built once from F at elaboration.
    function automatic logic [M-2:0][M-1:0] red_matrix();
        logic [M-2:0][M-1:0] mat;
        logic [M-1:0]        r;
        r = F;
        for (int j = 0; j < int'(M) - 1; j++) begin
            mat[j] = r;
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? F : '0);
        end
        return mat;
    endfunction

    localparam logic [M-2:0][M-1:0] RED = red_matrix();

    function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
        logic [2*M-2:0] p;
        logic [M-1:0]   r;
        p = '0;
        for (int i = 0; i < int'(M); i++) p[2*i] = x[i];
        r = p[M-1:0];
        for (int j = 0; j < int'(M) - 1; j++) begin
            if (p[M+j]) r = r ^ RED[j];
        end
        return r;
    endfunction

    state_t          state, state_next;
    logic [M-1:0]    acc, acc_next;
    logic [KW-1:0]   cnt, cnt_next;
    logic [KW-1:0]   step;
    logic [KW-1:0]   cnt_rem;
    logic [M-1:0]    tap;
    logic [M-1:0]    stage [S+1];

    // Chain of S squarers; the tap picks how many actually apply this cycle.
    assign stage[0] = acc;
    for (genvar g = 0; g < int'(S); g++) begin : g_stage
        assign stage[g+1] = gf_sq(stage[g]);
    end

    assign step    = (NW'(cnt) >= NW'(S)) ? KW'(S) : cnt;
    assign cnt_rem = cnt - step;

    always_comb begin
        tap = stage[1];
        for (int i = 1; i <= int'(S); i++) begin
            if (step == KW'(i)) tap = stage[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (cnt_rem == '0) state_next = FIN;
            end
            default: begin
                if (start) state_next = (k != '0) ? RUN : FIN;
                else       state_next = IDLE;
            end
        endcase
    end

    // Load on an accepted start, otherwise advance by the selected tap while running.
    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        if (state == RUN) begin
            acc_next = tap;
            cnt_next = cnt_rem;
        end else if (start) begin
            acc_next = a;
            cnt_next = k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            c    <= '0;
        end else begin
            acc  <= acc_next;
            cnt  <= cnt_next;
            busy <= (state_next == RUN);
            done <= (state_next == FIN);
            if (state_next == FIN) c <= acc_next;
        end
    end

endmodule
